// File: rtl/mc_main_control_if.sv
// Control bundle between the multicycle main control FSM and the datapath.
// Latency: n/a (signal grouping only).
// Backpressure: none; every control is a level that the datapath samples each cycle.
// Ports: master = FSM side (takes opcode/zero/negative, drives every control);
//        slave  = datapath side (mirror image).
interface mc_main_control_if;
  logic [5:0] opcode;
  logic       zero;
  logic       negative;
  logic       pcen;
  logic       iord;
  logic       memread;
  logic       memwrite;
  logic       irwrite;
  logic       regwrite;
  logic       memtoreg;
  logic       regdst;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic       aluop1;
  logic       aluop0;
  logic [1:0] pcsource;
  logic       memdatasrc;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  opcode, zero, negative,
    output pcen, iord, memread, memwrite, irwrite, regwrite, memtoreg, regdst,
           alusrca, alusrcb, aluop1, aluop0, pcsource, memdatasrc, illegal, state
  );

  modport slave (
    output opcode, zero, negative,
    input  pcen, iord, memread, memwrite, irwrite, regwrite, memtoreg, regdst,
           alusrca, alusrcb, aluop1, aluop0, pcsource, memdatasrc, illegal, state
  );
endinterface

// File: rtl/mc_main_control.sv
// Multicycle MIPS-subset main control FSM: sequences one instruction and drives all datapath controls.
// Latency: jump/branch 3, sw/R/nori/jspal 4, lw 5 cycles; illegal opcode 2 cycles.
// Backpressure: none; advances every clock, async reset returns to FETCH immediately.
// Ports: clk, reset (async, active-high); bus (mc_main_control_if.master): opcode/zero/negative in,
//        datapath enables, mux selects, aluop1/aluop0, illegal pulse and debug state out.
// Option: define MC_JSPAL_EN to add the jspal instruction (JSPALADR/JSPALWR, memdatasrc).
module mc_main_control #(
  parameter logic [3:0] RESET_STATE = 4'd0
`ifdef MC_JSPAL_EN
  , parameter logic [5:0] JSPAL_OP  = 6'b010011
`endif
) (
  input  logic               clk,
  input  logic               reset,
  mc_main_control_if.master  bus
);

  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] MEMADR   = 4'd2;
  localparam logic [3:0] MEMRD    = 4'd3;
  localparam logic [3:0] MEMWB    = 4'd4;
  localparam logic [3:0] MEMWR    = 4'd5;
  localparam logic [3:0] REXEC    = 4'd6;
  localparam logic [3:0] RWB      = 4'd7;
  localparam logic [3:0] BRANCH   = 4'd8;
  localparam logic [3:0] JUMP     = 4'd9;
  localparam logic [3:0] NORIEXEC = 4'd10;
  localparam logic [3:0] NORIWB   = 4'd11;
`ifdef MC_JSPAL_EN
  localparam logic [3:0] JSPALADR = 4'd12;
  localparam logic [3:0] JSPALWR  = 4'd13;
`endif

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BLTZ = 6'b000001;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_NORI = 6'b001110;

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic       op_known;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= RESET_STATE;
    else       state_q <= state_d;
  end

  // Opcode legality, used for the illegal pulse in DECODE
  always_comb begin
    op_known = 1'b0;
    case (bus.opcode)
      OP_R, OP_LW, OP_SW, OP_BEQ, OP_BLTZ, OP_J, OP_NORI: op_known = 1'b1;
      default: op_known = 1'b0;
    endcase
`ifdef MC_JSPAL_EN
    if (bus.opcode == JSPAL_OP) op_known = 1'b1;
`endif
  end

  // Next-state logic; opcode only matters in DECODE and MEMADR
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:    state_d = DECODE;
      DECODE: begin
        case (bus.opcode)
          OP_R:            state_d = REXEC;
          OP_LW, OP_SW:    state_d = MEMADR;
          OP_BEQ, OP_BLTZ: state_d = BRANCH;
          OP_J:            state_d = JUMP;
          OP_NORI:         state_d = NORIEXEC;
          default:         state_d = FETCH;
        endcase
`ifdef MC_JSPAL_EN
        if (bus.opcode == JSPAL_OP) state_d = JSPALADR;
`endif
      end
      // An opcode that is neither lw nor sw here means IR was disturbed; abandon safely.
      MEMADR: begin
        if      (bus.opcode == OP_LW) state_d = MEMRD;
        else if (bus.opcode == OP_SW) state_d = MEMWR;
        else                          state_d = FETCH;
      end
      MEMRD:    state_d = MEMWB;
      REXEC:    state_d = RWB;
      NORIEXEC: state_d = NORIWB;
`ifdef MC_JSPAL_EN
      JSPALADR: state_d = JSPALWR;
`endif
      default:  state_d = FETCH;
    endcase
  end

  // Output decode: Moore except branch pcen and the DECODE illegal pulse
  always_comb begin
    bus.pcen       = 1'b0;
    bus.iord       = 1'b0;
    bus.memread    = 1'b0;
    bus.memwrite   = 1'b0;
    bus.irwrite    = 1'b0;
    bus.regwrite   = 1'b0;
    bus.memtoreg   = 1'b0;
    bus.regdst     = 1'b0;
    bus.alusrca    = 1'b0;
    bus.alusrcb    = 2'b00;
    bus.aluop1     = 1'b0;
    bus.aluop0     = 1'b0;
    bus.pcsource   = 2'b00;
    bus.memdatasrc = 1'b0;
    bus.illegal    = 1'b0;
    case (state_q)
      FETCH: begin
        bus.memread = 1'b1;
        bus.irwrite = 1'b1;
        bus.alusrcb = 2'b01;
        bus.pcen    = 1'b1;
      end
      DECODE: begin
        bus.alusrcb = 2'b11;
        bus.illegal = ~op_known;
      end
      MEMADR: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
      end
      MEMRD: begin
        bus.memread = 1'b1;
        bus.iord    = 1'b1;
      end
      MEMWB: begin
        bus.regwrite = 1'b1;
        bus.memtoreg = 1'b1;
      end
      MEMWR: begin
        bus.memwrite = 1'b1;
        bus.iord     = 1'b1;
      end
      REXEC: begin
        bus.alusrca = 1'b1;
        bus.aluop1  = 1'b1;
      end
      RWB: begin
        bus.regwrite = 1'b1;
        bus.regdst   = 1'b1;
      end
      BRANCH: begin
        bus.alusrca  = 1'b1;
        bus.aluop0   = 1'b1;
        bus.pcsource = 2'b01;
        // bltz has rt=0, so the subtract yields rs and its sign is the test
        bus.pcen     = ((bus.opcode == OP_BEQ)  & bus.zero) |
                       ((bus.opcode == OP_BLTZ) & bus.negative);
      end
      JUMP: begin
        bus.pcsource = 2'b10;
        bus.pcen     = 1'b1;
      end
      NORIEXEC: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
        bus.aluop1  = 1'b1;
        bus.aluop0  = 1'b1;
      end
      NORIWB: begin
        bus.regwrite = 1'b1;
      end
`ifdef MC_JSPAL_EN
      JSPALADR: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
      end
      // PC+4 is stored at rs+imm while the PC loads rs+imm from ALUOut
      JSPALWR: begin
        bus.memwrite   = 1'b1;
        bus.iord       = 1'b1;
        bus.memdatasrc = 1'b1;
        bus.pcsource   = 2'b01;
        bus.pcen       = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign bus.state = state_q;

endmodule

// File: tb/tb_mc_main_control.sv
// Directed self-checking bench for mc_main_control.
// Latency: n/a (stimulus only).
// Backpressure: n/a.
module tb_mc_main_control;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  mc_main_control_if bus ();

  mc_main_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Starts from t=0 with reset high; ends at a negedge in FETCH with reset low.
  task automatic test_reset();
    reset = 1'b1;
    bus.opcode = 6'b000000;
    bus.zero = 1'b0;
    bus.negative = 1'b0;
    #2;
    checks++; if (bus.state !== 4'd0) begin errors++; $display("FAIL reset_state got %0d want 0", bus.state); end
    checks++; if ({bus.memread, bus.irwrite, bus.pcen} !== 3'b111) begin errors++; $display("FAIL reset_fetch_en got %b want 111", {bus.memread, bus.irwrite, bus.pcen}); end
    checks++; if (bus.alusrcb !== 2'b01) begin errors++; $display("FAIL reset_alusrcb got %b want 01", bus.alusrcb); end
    checks++; if ({bus.regwrite, bus.memwrite, bus.illegal} !== 3'b000) begin errors++; $display("FAIL reset_zero_out got %b want 000", {bus.regwrite, bus.memwrite, bus.illegal}); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++; if (bus.state !== 4'd0) begin errors++; $display("FAIL reset_release got %0d want 0", bus.state); end
  endtask

  task automatic test_lw();
    logic [3:0] seq [5];
    seq = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    bus.opcode = 6'b100011;
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.state !== seq[i]) begin errors++; $display("FAIL lw_state[%0d] got %0d want %0d", i, bus.state, seq[i]); end
      if (i <= 2) begin
        checks++; if ({bus.aluop1, bus.aluop0} !== 2'b00) begin errors++; $display("FAIL lw_aluop[%0d] got %b want 00", i, {bus.aluop1, bus.aluop0}); end
      end
      checks++; if (bus.regwrite !== (i == 4)) begin errors++; $display("FAIL lw_regwrite[%0d] got %b want %b", i, bus.regwrite, (i == 4)); end
      checks++; if (bus.memtoreg !== (i == 4)) begin errors++; $display("FAIL lw_memtoreg[%0d] got %b want %b", i, bus.memtoreg, (i == 4)); end
      @(negedge clk);
    end
    checks++; if (bus.state !== 4'd0) begin errors++; $display("FAIL lw_return got %0d want 0", bus.state); end
  endtask

  task automatic test_rformat();
    bus.opcode = 6'b000000;
    @(negedge clk);
    checks++; if (bus.state !== 4'd1) begin errors++; $display("FAIL r_decode got %0d want 1", bus.state); end
    @(negedge clk);
    checks++; if (bus.state !== 4'd6) begin errors++; $display("FAIL r_rexec_state got %0d want 6", bus.state); end
    checks++; if ({bus.aluop1, bus.aluop0, bus.alusrcb, bus.alusrca} !== 5'b10001) begin errors++; $display("FAIL r_rexec_ctl got %b want 10001", {bus.aluop1, bus.aluop0, bus.alusrcb, bus.alusrca}); end
    @(negedge clk);
    checks++; if (bus.state !== 4'd7) begin errors++; $display("FAIL r_rwb_state got %0d want 7", bus.state); end
    checks++; if ({bus.regwrite, bus.regdst, bus.memtoreg} !== 3'b110) begin errors++; $display("FAIL r_rwb_ctl got %b want 110", {bus.regwrite, bus.regdst, bus.memtoreg}); end
    @(negedge clk);
    checks++; if (bus.state !== 4'd0) begin errors++; $display("FAIL r_return got %0d want 0", bus.state); end
  endtask

  task automatic test_branch(input logic [5:0] op, input logic z, input logic n, input logic exp_pcen);
    bus.opcode = op;
    bus.zero = z;
    bus.negative = n;
    @(negedge clk);
    checks++; if (bus.state !== 4'd1) begin errors++; $display("FAIL br_decode op=%b got %0d want 1", op, bus.state); end
    @(negedge clk);
    checks++; if (bus.state !== 4'd8) begin errors++; $display("FAIL br_state op=%b got %0d want 8", op, bus.state); end
    checks++; if (bus.pcen !== exp_pcen) begin errors++; $display("FAIL br_pcen op=%b z=%b n=%b got %b want %b", op, z, n, bus.pcen, exp_pcen); end
    checks++; if ({bus.pcsource, bus.aluop1, bus.aluop0, bus.alusrcb} !== 6'b010100) begin errors++; $display("FAIL br_ctl op=%b got %b want 010100", op, {bus.pcsource, bus.aluop1, bus.aluop0, bus.alusrcb}); end
    @(negedge clk);
    checks++; if (bus.state !== 4'd0) begin errors++; $display("FAIL br_return op=%b got %0d want 0", op, bus.state); end
    bus.zero = 1'b0;
    bus.negative = 1'b0;
  endtask

  task automatic test_nori();
    bus.opcode = 6'b001110;
    @(negedge clk);
    @(negedge clk);
    checks++; if (bus.state !== 4'd10) begin errors++; $display("FAIL nori_exec_state got %0d want 10", bus.state); end
    checks++; if ({bus.aluop1, bus.aluop0, bus.alusrcb, bus.alusrca} !== 5'b11101) begin errors++; $display("FAIL nori_exec_ctl got %b want 11101", {bus.aluop1, bus.aluop0, bus.alusrcb, bus.alusrca}); end
    @(negedge clk);
    checks++; if (bus.state !== 4'd11) begin errors++; $display("FAIL nori_wb_state got %0d want 11", bus.state); end
    checks++; if ({bus.regwrite, bus.regdst} !== 2'b10) begin errors++; $display("FAIL nori_wb_ctl got %b want 10", {bus.regwrite, bus.regdst}); end
    @(negedge clk);
    checks++; if (bus.state !== 4'd0) begin errors++; $display("FAIL nori_return got %0d want 0", bus.state); end
  endtask

  task automatic test_illegal(input logic [5:0] op);
    bus.opcode = op;
    checks++; if (bus.illegal !== 1'b0) begin errors++; $display("FAIL ill_fetch op=%b got %b want 0", op, bus.illegal); end
    @(negedge clk);
    checks++; if ({bus.state, bus.illegal} !== 5'b00011) begin errors++; $display("FAIL ill_decode op=%b got %b want 00011", op, {bus.state, bus.illegal}); end
    checks++; if ({bus.regwrite, bus.memwrite, bus.irwrite, bus.pcen} !== 4'b0000) begin errors++; $display("FAIL ill_writes op=%b got %b want 0000", op, {bus.regwrite, bus.memwrite, bus.irwrite, bus.pcen}); end
    @(negedge clk);
    checks++; if ({bus.state, bus.illegal} !== 5'b00000) begin errors++; $display("FAIL ill_return op=%b got %b want 00000", op, {bus.state, bus.illegal}); end
  endtask

`ifdef MC_JSPAL_EN
  task automatic test_jspal();
    bus.opcode = 6'b010011;
    @(negedge clk);
    @(negedge clk);
    checks++; if (bus.state !== 4'd12) begin errors++; $display("FAIL jspal_adr got %0d want 12", bus.state); end
    @(negedge clk);
    checks++; if (bus.state !== 4'd13) begin errors++; $display("FAIL jspal_wr got %0d want 13", bus.state); end
    checks++; if ({bus.memwrite, bus.iord, bus.memdatasrc, bus.pcsource, bus.pcen, bus.regwrite} !== 7'b1110110) begin errors++; $display("FAIL jspal_ctl got %b want 1110110", {bus.memwrite, bus.iord, bus.memdatasrc, bus.pcsource, bus.pcen, bus.regwrite}); end
    @(negedge clk);
    checks++; if (bus.state !== 4'd0) begin errors++; $display("FAIL jspal_return got %0d want 0", bus.state); end
  endtask
`endif

  // sw interrupted by reset in MEMWR, then a clean jump afterwards
  task automatic test_reset_during_sw();
    bus.opcode = 6'b101011;
    @(negedge clk);
    @(negedge clk);
    checks++; if (bus.state !== 4'd2) begin errors++; $display("FAIL sw_memadr got %0d want 2", bus.state); end
    @(negedge clk);
    checks++; if ({bus.state, bus.memwrite, bus.iord, bus.regwrite} !== 7'b0101110) begin errors++; $display("FAIL sw_memwr got %b want 0101110", {bus.state, bus.memwrite, bus.iord, bus.regwrite}); end
    #1 reset = 1'b1;
    #1;
    checks++; if ({bus.state, bus.memwrite} !== 5'b00000) begin errors++; $display("FAIL sw_async_reset got %b want 00000", {bus.state, bus.memwrite}); end
    checks++; if (bus.memread !== 1'b1) begin errors++; $display("FAIL sw_reset_fetch got %b want 1", bus.memread); end
    bus.opcode = 6'b000010;
    @(negedge clk);
    reset = 1'b0;
    checks++; if ({bus.state, bus.memwrite} !== 5'b00000) begin errors++; $display("FAIL sw_post_reset got %b want 00000", {bus.state, bus.memwrite}); end
    @(negedge clk);
    checks++; if (bus.state !== 4'd1) begin errors++; $display("FAIL j_decode got %0d want 1", bus.state); end
    @(negedge clk);
    checks++; if ({bus.state, bus.pcen, bus.pcsource, bus.memwrite} !== 8'b10011100) begin errors++; $display("FAIL j_jump got %b want 10011100", {bus.state, bus.pcen, bus.pcsource, bus.memwrite}); end
    @(negedge clk);
    checks++; if (bus.state !== 4'd0) begin errors++; $display("FAIL j_return got %0d want 0", bus.state); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_lw();
    test_rformat();
    test_branch(6'b000100, 1'b1, 1'b0, 1'b1);
    test_branch(6'b000100, 1'b0, 1'b1, 1'b0);
    test_branch(6'b000001, 1'b0, 1'b1, 1'b1);
    test_branch(6'b000001, 1'b1, 1'b0, 1'b0);
    test_nori();
    test_illegal(6'b111111);
`ifdef MC_JSPAL_EN
    test_jspal();
`else
    test_illegal(6'b010011);
`endif
    test_reset_during_sw();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
